// File: rtl/spi_mcp4822.sv
// spi_mcp4822: SPI master for the MCP4822 12-bit dual DAC.
// Captures each rising edge of the ADC data-valid level, sends one 16-bit
// command frame (mode 0,0, MSB first) and then pulses LDAC to update the DAC.
// A one-deep pending buffer holds a sample that arrives mid-frame; a second
// arrival overwrites it and sets the sticky overrun flag.
//
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   i_DATA[11:0] sample word from the ADC master
//   i_DV         ADC data-valid level (one capture per rising edge)
//   o_SCK/o_MOSI SPI clock and data to DAC SDI
//   o_CS         chip select, active low
//   o_LDAC       DAC latch strobe, active low
//   o_BUSY       high from frame start until return to IDLE
//   o_DONE       one-cycle pulse when the frame and LDAC pulse complete
//   o_OVERRUN    sticky, set when a pending sample is overwritten
module spi_mcp4822 #(
    parameter int HALF_SCK    = 4,
    parameter int CSS_CYCLES  = 8,
    parameter int LDAC_CYCLES = 13,
    parameter bit CHANNEL     = 1'b0,
    parameter bit GAIN_1X     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] i_DATA,
    input  logic        i_DV,
    output logic        o_SCK,
    output logic        o_MOSI,
    output logic        o_CS,
    output logic        o_LDAC,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_OVERRUN
);
    localparam int PH_M1  = (HALF_SCK > CSS_CYCLES) ? HALF_SCK : CSS_CYCLES;
    localparam int PH_MAX = (PH_M1 > LDAC_CYCLES) ? PH_M1 : LDAC_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC, DONE} state_t;

    state_t          state, state_d;
    logic            dv_q;
    logic            dv_rise;
    logic            pend_vld;
    logic [11:0]     pend_data;
    logic [15:0]     shreg;
    logic [3:0]      bit_cnt;
    logic [PH_W-1:0] ph_cnt;
    logic            ph_done;
    logic            sck_hi;

    function automatic logic [15:0] cmd_word(input logic [11:0] d);
        return {CHANNEL, 1'b0, GAIN_1X, 1'b1, d};
    endfunction

    assign dv_rise = i_DV & ~dv_q;
    assign ph_done = (ph_cnt == '0);

    // SCK comes straight from a flop that is only set inside SHIFT, and the
    // shift register drains to zero by the end of the frame, so both SPI
    // lines are glitch-free and idle low without extra gating.
    assign o_SCK  = sck_hi;
    assign o_MOSI = shreg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (dv_rise || pend_vld)                 state_d = SETUP;
            SETUP:   if (ph_done)                             state_d = SHIFT;
            SHIFT:   if (ph_done && sck_hi && bit_cnt == '0)  state_d = HOLD;
            HOLD:    if (ph_done)                             state_d = LDAC;
            LDAC:    if (ph_done)                             state_d = DONE;
            DONE:                                             state_d = IDLE;
            default:                                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q      <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ph_cnt    <= '0;
            sck_hi    <= 1'b0;
            o_CS      <= 1'b1;
            o_LDAC    <= 1'b1;
            o_BUSY    <= 1'b0;
            o_DONE    <= 1'b0;
            o_OVERRUN <= 1'b0;
        end else begin
            dv_q <= i_DV;

            // Any arrival while a sample is already waiting loses the older one.
            if (dv_rise) begin
                if (pend_vld) o_OVERRUN <= 1'b1;
                if (state != IDLE) begin
                    pend_vld  <= 1'b1;
                    pend_data <= i_DATA;
                end
            end

            case (state)
                IDLE: begin
                    if (dv_rise || pend_vld) begin
                        // A fresh edge is newer than anything pending.
                        shreg    <= cmd_word(dv_rise ? i_DATA : pend_data);
                        pend_vld <= 1'b0;
                        ph_cnt   <= PH_W'(CSS_CYCLES - 1);
                    end
                end
                SETUP: begin
                    if (ph_done) begin
                        ph_cnt  <= PH_W'(HALF_SCK - 1);
                        sck_hi  <= 1'b0;
                        bit_cnt <= 4'd15;
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (ph_done) begin
                        ph_cnt <= PH_W'(HALF_SCK - 1);
                        if (!sck_hi) begin
                            sck_hi <= 1'b1;
                        end else begin
                            // Falling edge: next bit goes out at the start of
                            // the low phase; the 16th shift empties the register.
                            sck_hi <= 1'b0;
                            shreg  <= {shreg[14:0], 1'b0};
                            if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (ph_done) ph_cnt <= PH_W'(LDAC_CYCLES - 1);
                    else         ph_cnt <= ph_cnt - 1'b1;
                end
                LDAC: begin
                    if (!ph_done) ph_cnt <= ph_cnt - 1'b1;
                end
                default: ;
            endcase

            // Strobes are registered from the next state so they line up
            // exactly with the state they describe.
            o_CS   <= !(state_d inside {SETUP, SHIFT, HOLD});
            o_LDAC <= (state_d != LDAC);
            o_BUSY <= (state_d != IDLE);
            o_DONE <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_spi_mcp4822.sv
module tb_spi_mcp4822;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data = '0;
    logic        dv = 1'b0;

    logic a_sck, a_mosi, a_cs, a_ldac, a_busy, a_done, a_ovr;
    logic b_sck, b_mosi, b_cs, b_ldac, b_busy, b_done, b_ovr;

    always #4 clk = ~clk;

    spi_mcp4822 dut_a (
        .clk(clk), .rst_n(rst_n), .i_DATA(data), .i_DV(dv),
        .o_SCK(a_sck), .o_MOSI(a_mosi), .o_CS(a_cs), .o_LDAC(a_ldac),
        .o_BUSY(a_busy), .o_DONE(a_done), .o_OVERRUN(a_ovr)
    );

    // Second instance: DAC B, 2x gain.
    spi_mcp4822 #(.CHANNEL(1'b1), .GAIN_1X(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_DATA(data), .i_DV(dv),
        .o_SCK(b_sck), .o_MOSI(b_mosi), .o_CS(b_cs), .o_LDAC(b_ldac),
        .o_BUSY(b_busy), .o_DONE(b_done), .o_OVERRUN(b_ovr)
    );

    typedef struct {
        logic [15:0] word;
        int nbits, cs_len, ldac_len, busy_len, gap;
    } frame_t;
    typedef struct {
        logic [15:0] word;
        int gmin, gmax, hmin, hmax;
    } bframe_t;
    typedef struct {
        logic [11:0] d;
        int          hold;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    frame_t      rec_q[$];
    bframe_t     brec_q[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int n_cmp = 0, n_bad = 0, rd = 0;

    // ---------------- monitor, DUT A ----------------
    logic [15:0] m_bits = '0;
    int m_nb = 0, m_cs = 0, m_ld = 0, m_bz = 0, m_gap = 0;
    int m_cyc = 0, m_last_done = 0, viol = 0;
    logic p_sck = 1'b0, p_cs = 1'b1;

    always @(negedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_bits = '0; m_nb = 0; m_cs = 0; m_ld = 0; m_bz = 0;
            p_sck = 1'b0; p_cs = 1'b1;
        end else begin
            if (a_sck && !p_sck) begin m_bits = {m_bits[14:0], a_mosi}; m_nb++; end
            if (!a_cs && p_cs) m_gap = m_cyc - m_last_done;
            if (!a_cs) m_cs++;
            if (!a_ldac) m_ld++;
            if (a_busy) m_bz++;
            if (a_cs && (a_sck || a_mosi)) viol++;
            if (a_done) begin
                rec_q.push_back('{m_bits, m_nb, m_cs, m_ld, m_bz, m_gap});
                m_last_done = m_cyc;
                m_bits = '0; m_nb = 0; m_cs = 0; m_ld = 0; m_bz = 0;
            end
            p_sck = a_sck; p_cs = a_cs;
        end
    end

    // ---------------- monitor, DUT B (word + SCK timing) ----------------
    logic [15:0] n_bits = '0;
    int n_nb = 0, n_last_rise = 0, n_hi = 0;
    int n_gmin = 1000, n_gmax = 0, n_hmin = 1000, n_hmax = 0;
    logic q_sck = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_bits = '0; n_nb = 0; n_hi = 0; q_sck = 1'b0;
            n_gmin = 1000; n_gmax = 0; n_hmin = 1000; n_hmax = 0;
        end else begin
            if (b_sck && !q_sck) begin
                if (n_nb > 0) begin
                    if (m_cyc - n_last_rise < n_gmin) n_gmin = m_cyc - n_last_rise;
                    if (m_cyc - n_last_rise > n_gmax) n_gmax = m_cyc - n_last_rise;
                end
                n_last_rise = m_cyc;
                n_bits = {n_bits[14:0], b_mosi};
                n_nb++;
            end
            if (b_sck) n_hi++;
            if (!b_sck && q_sck) begin
                if (n_hi < n_hmin) n_hmin = n_hi;
                if (n_hi > n_hmax) n_hmax = n_hi;
                n_hi = 0;
            end
            if (b_done) begin
                brec_q.push_back('{n_bits, n_gmin, n_gmax, n_hmin, n_hmax});
                n_bits = '0; n_nb = 0;
                n_gmin = 1000; n_gmax = 0; n_hmin = 1000; n_hmax = 0;
            end
            q_sck = b_sck;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise dv with a new word, optionally queuing the frames it should produce.
    task automatic pulse(input logic [11:0] d, input int hold, input bit push,
                         input logic [15:0] wa, input logic [15:0] wb);
        data = d;
        dv   = 1'b1;
        if (push) begin exp_a.push_back(wa); exp_b.push_back(wb); end
        tick(hold);
        dv = 1'b0;
    endtask

    // Wait (bounded) for n more frames, then score them against the queues.
    task automatic drain(input int n, input int limit, output int gap);
        int t;
        frame_t  f;
        bframe_t g;
        t   = 0;
        gap = -1;
        while ((rec_q.size() < rd + n || brec_q.size() < rd + n) && t < limit) begin
            tick(1);
            t++;
        end
        check("frame_timeout", (rec_q.size() >= rd + n && brec_q.size() >= rd + n) ? 1 : 0, 1);
        for (int k = 0; k < n; k++) begin
            if (rd >= rec_q.size() || rd >= brec_q.size() || rd >= exp_a.size()) break;
            f = rec_q[rd];
            g = brec_q[rd];
            check("a_word",     f.word,     exp_a[rd]);
            check("a_nbits",    f.nbits,    16);
            check("a_cs_low",   f.cs_len,   140);
            check("a_ldac_low", f.ldac_len, 13);
            check("a_busy_len", f.busy_len, 154);
            check("b_word",     g.word,     exp_b[rd]);
            check("b_sck_period_min", g.gmin, 8);
            check("b_sck_period_max", g.gmax, 8);
            check("b_sck_high_min",   g.hmin, 4);
            check("b_sck_high_max",   g.hmax, 4);
            gap = f.gap;
            rd++;
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[5];
    int   gap;
    logic [11:0] r;

    initial begin
        // expected words: {CHANNEL, 0, GA, SHDN=1, data}; A = 0,0,1,1  B = 1,0,0,1
        vecs[0] = '{12'hA5C, 200, 16'h3A5C, 16'h9A5C};
        vecs[1] = '{12'hFFF,   3, 16'h3FFF, 16'h9FFF};
        vecs[2] = '{12'h000,   1, 16'h3000, 16'h9000};
        vecs[3] = '{12'h800,  50, 16'h3800, 16'h9800};
        vecs[4] = '{12'h7FF,   2, 16'h37FF, 16'h97FF};

        tick(3);
        check("rst_cs",   a_cs,   1);
        check("rst_ldac", a_ldac, 1);
        check("rst_sck",  a_sck,  0);
        check("rst_mosi", a_mosi, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ovr",  a_ovr,  0);
        rst_n = 1'b1;
        tick(5);

        // table: one frame per dv edge, held-high dv gives one capture
        for (int i = 0; i < 5; i++) begin
            pulse(vecs[i].d, vecs[i].hold, 1'b1, vecs[i].exp_a, vecs[i].exp_b);
            drain(1, 400, gap);
            tick(100);
            check("single_frame", rec_q.size(), rd);
        end
        check("ovr_after_table", a_ovr, 0);

        // pending: second edge around clock 50 of a frame
        pulse(12'h456, 2, 1'b1, 16'h3456, 16'h9456);
        tick(48);
        pulse(12'h123, 2, 1'b1, 16'h3123, 16'h9123);
        drain(2, 600, gap);
        check("pending_restart_gap", gap, 2);
        check("pending_no_ovr", a_ovr, 0);
        tick(20);

        // overrun: 111 is overwritten by 222
        pulse(12'h999, 2, 1'b1, 16'h3999, 16'h9999);
        tick(20);
        pulse(12'h111, 2, 1'b0, 16'h0, 16'h0);
        tick(20);
        pulse(12'h222, 2, 1'b1, 16'h3222, 16'h9222);
        drain(2, 600, gap);
        check("ovr_set_a", a_ovr, 1);
        check("ovr_set_b", b_ovr, 1);
        tick(200);
        check("ovr_sticky", a_ovr, 1);
        check("no_extra_after_ovr", rec_q.size(), rd);

        // mid-frame reset around clock 70
        pulse(12'h777, 2, 1'b0, 16'h0, 16'h0);
        tick(68);
        check("frame_active_before_rst", a_cs, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_cs",   a_cs,   1);
        check("midrst_sck",  a_sck,  0);
        check("midrst_ldac", a_ldac, 1);
        check("midrst_mosi", a_mosi, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_ovr",  a_ovr,  0);
        tick(3);
        rst_n = 1'b1;
        tick(300);
        check("no_frame_after_rst", rec_q.size(), rd);
        check("idle_after_rst", a_busy, 0);

        // ADC passthrough: 5 sample periods of 2500 clocks
        for (int p = 0; p < 5; p++) begin
            r = 12'($urandom_range(0, 4095));
            pulse(r, 100, 1'b1, {4'h3, r}, {4'h9, r});
            tick(2400);
        end
        drain(5, 1000, gap);

        check("idle_lines_quiet", viol, 0);
        check("total_frames", rec_q.size(), exp_a.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
